// File: rtl/sparse_chunk_writer.sv
// Dense-to-sparse chunk writer: per-beat sparsemap and lane compaction plus ping-pong buffer bookkeeping.
// Optional macro SPARSE_CHUNK_NNZ_COUNT_EN adds nnz_count_o (nonzero bytes of the last completed chunk).
module sparse_chunk_writer #(
  parameter int BUS_SIZE   = 32,
  parameter int CHUNK_SIZE = 128,
  localparam int WR_DAT_CYC_NUM = CHUNK_SIZE / BUS_SIZE,
  localparam int CW = (WR_DAT_CYC_NUM > 1) ? $clog2(WR_DAT_CYC_NUM) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  dense_valid_i,
  input  logic [BUS_SIZE*8-1:0] dense_data_i,
  output logic                  dense_ready_o,
  output logic [BUS_SIZE-1:0]   wr_sparsemap_o,
  output logic [BUS_SIZE*8-1:0] wr_nonzero_data_o,
  output logic                  wr_valid_o,
  output logic [CW-1:0]         wr_count_o,
  output logic                  wr_sel_o,
  output logic                  rd_sel_o,
  output logic                  rd_avail_o,
  input  logic                  rd_release_i,
  output logic                  chunk_done_o
`ifdef SPARSE_CHUNK_NNZ_COUNT_EN
  ,
  output logic [$clog2(CHUNK_SIZE):0] nnz_count_o
`endif
);

  // Handshake: a beat transfers on a rising clk_i edge where dense_valid_i && dense_ready_o;
  // ready depends only on registered state, never on dense_valid_i.

  typedef enum logic {
    BUF_EMPTY = 1'b0,
    BUF_FULL  = 1'b1
  } buf_state_t;

  buf_state_t buf_state      [2];
  buf_state_t buf_state_next [2];

  logic          fill_sel;
  logic [CW-1:0] beat_cnt;
  logic          accept;
  logic          last_beat;
  logic          release_ok;

  logic [BUS_SIZE-1:0]   map_c;
  logic [BUS_SIZE*8-1:0] packed_c;

  assign dense_ready_o = (buf_state[fill_sel] == BUF_EMPTY);
  assign rd_avail_o    = (buf_state[rd_sel_o] == BUF_FULL);
  assign accept        = dense_valid_i && dense_ready_o;
  assign last_beat     = accept && (beat_cnt == CW'(WR_DAT_CYC_NUM - 1));
  assign release_ok    = rd_release_i && rd_avail_o;

  // Lane j of the packed word takes the j-th nonzero input byte, scanning from lane 0 upward.
  always_comb begin
    int n;
    map_c    = '0;
    packed_c = '0;
    n        = 0;
    for (int k = 0; k < BUS_SIZE; k++) begin
      if (dense_data_i[k*8 +: 8] != 8'd0) begin
        map_c[k]             = 1'b1;
        packed_c[n*8 +: 8]   = dense_data_i[k*8 +: 8];
        n                    = n + 1;
      end
    end
  end

  // The released buffer is never the one being filled, so both updates can land in one cycle.
  always_comb begin
    buf_state_next[0] = buf_state[0];
    buf_state_next[1] = buf_state[1];
    if (release_ok) buf_state_next[rd_sel_o] = BUF_EMPTY;
    if (last_beat)  buf_state_next[fill_sel] = BUF_FULL;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      buf_state[0] <= BUF_EMPTY;
      buf_state[1] <= BUF_EMPTY;
    end else begin
      buf_state[0] <= buf_state_next[0];
      buf_state[1] <= buf_state_next[1];
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      fill_sel          <= 1'b0;
      rd_sel_o          <= 1'b0;
      beat_cnt          <= '0;
      wr_valid_o        <= 1'b0;
      chunk_done_o      <= 1'b0;
      wr_count_o        <= '0;
      wr_sel_o          <= 1'b0;
      wr_sparsemap_o    <= '0;
      wr_nonzero_data_o <= '0;
    end else begin
      wr_valid_o   <= accept;
      chunk_done_o <= last_beat;
      if (release_ok) rd_sel_o <= ~rd_sel_o;
      if (accept) begin
        wr_count_o        <= beat_cnt;
        wr_sel_o          <= fill_sel;
        wr_sparsemap_o    <= map_c;
        wr_nonzero_data_o <= packed_c;
        beat_cnt          <= last_beat ? '0 : beat_cnt + CW'(1);
        if (last_beat) fill_sel <= ~fill_sel;
      end
    end
  end

`ifdef SPARSE_CHUNK_NNZ_COUNT_EN
  localparam int NW = $clog2(CHUNK_SIZE) + 1;

  logic [NW-1:0] beat_nnz;
  logic [NW-1:0] nnz_acc;
  logic [NW-1:0] nnz_sum;

  always_comb begin
    beat_nnz = '0;
    for (int k = 0; k < BUS_SIZE; k++) beat_nnz = beat_nnz + NW'(map_c[k]);
  end

  // The first beat of a chunk starts from zero instead of the previous chunk's total.
  assign nnz_sum = ((beat_cnt == '0) ? '0 : nnz_acc) + beat_nnz;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      nnz_acc     <= '0;
      nnz_count_o <= '0;
    end else if (accept) begin
      nnz_acc <= nnz_sum;
      if (last_beat) nnz_count_o <= nnz_sum;
    end
  end
`endif

endmodule

// File: tb/tb_sparse_chunk_writer.sv
// Directed bench for sparse_chunk_writer: chunk-level reference model, per-cycle compare, literal spot checks.
// Define SPARSE_CHUNK_NNZ_COUNT_EN to also check nnz_count_o.
module tb_sparse_chunk_writer;

  localparam int CW    = 2;
  localparam int BEATS = 4;
  localparam int REC_W = 1 + 1 + CW + 32 + 256;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b0;
  logic         dense_valid_i = 1'b0;
  logic [255:0] dense_data_i = '0;
  logic         dense_ready_o;
  logic [31:0]  wr_sparsemap_o;
  logic [255:0] wr_nonzero_data_o;
  logic         wr_valid_o;
  logic [CW-1:0] wr_count_o;
  logic         wr_sel_o;
  logic         rd_sel_o;
  logic         rd_avail_o;
  logic         rd_release_i = 1'b0;
  logic         chunk_done_o;
`ifdef SPARSE_CHUNK_NNZ_COUNT_EN
  logic [7:0]   nnz_count_o;
`endif

  sparse_chunk_writer dut (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .dense_valid_i     (dense_valid_i),
    .dense_data_i      (dense_data_i),
    .dense_ready_o     (dense_ready_o),
    .wr_sparsemap_o    (wr_sparsemap_o),
    .wr_nonzero_data_o (wr_nonzero_data_o),
    .wr_valid_o        (wr_valid_o),
    .wr_count_o        (wr_count_o),
    .wr_sel_o          (wr_sel_o),
    .rd_sel_o          (rd_sel_o),
    .rd_avail_o        (rd_avail_o),
    .rd_release_i      (rd_release_i),
    .chunk_done_o      (chunk_done_o)
`ifdef SPARSE_CHUNK_NNZ_COUNT_EN
    ,
    .nnz_count_o       (nnz_count_o)
`endif
  );

  // Clock/reset block
  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: counts of completed/released chunks and accepted beats since reset.
  int completed = 0;
  int released  = 0;
  int beats     = 0;
  int chunk_nnz = 0;
  int e_nnz     = 0;
  logic [REC_W-1:0] exp_q[$];
  logic [REC_W-1:0] last_rec = '0;

  function automatic void compact(input logic [255:0] d, output logic [31:0] m, output logic [255:0] p);
    logic [7:0] q[$];
    m = '0;
    p = '0;
    for (int k = 0; k < 32; k++) begin
      if (d[k*8 +: 8] != 8'd0) begin
        m[k] = 1'b1;
        q.push_back(d[k*8 +: 8]);
      end
    end
    for (int j = 0; j < q.size(); j++) p[j*8 +: 8] = q[j];
  endfunction

  always @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      completed = 0;
      released  = 0;
      beats     = 0;
      chunk_nnz = 0;
      e_nnz     = 0;
      last_rec  = '0;
      exp_q.delete();
    end else begin
      int in_flight;
      bit acc, rel, done;
      logic [31:0]  m;
      logic [255:0] p;
      in_flight = completed - released;
      acc = dense_valid_i && (in_flight < 2);
      rel = rd_release_i && (in_flight > 0);
      if (acc) begin
        compact(dense_data_i, m, p);
        done = ((beats % BEATS) == BEATS - 1);
        exp_q.push_back({done, 1'(completed % 2), CW'(beats % BEATS), m, p});
        chunk_nnz += $countones(m);
        beats++;
        if (done) begin
          e_nnz     = chunk_nnz;
          chunk_nnz = 0;
          completed++;
        end
      end
      if (rel) released++;
    end
  end

  // Scoreboard compare, every cycle on the falling edge
  always @(negedge clk_i) begin
    logic [REC_W-1:0] rec;
    check("dense_ready", dense_ready_o, (completed - released) < 2);
    check("rd_avail", rd_avail_o, (completed - released) > 0);
    check("rd_sel", rd_sel_o, released % 2);
    if (exp_q.size() != 0) begin
      rec = exp_q.pop_front();
      check("wr_valid", wr_valid_o, 1'b1);
      check("chunk_done", chunk_done_o, rec[REC_W-1]);
      last_rec = rec;
    end else begin
      rec = last_rec;
      check("wr_valid", wr_valid_o, 1'b0);
      check("chunk_done", chunk_done_o, 1'b0);
    end
    check("wr_sel", wr_sel_o, rec[REC_W-2]);
    check("wr_count", wr_count_o, rec[288 +: CW]);
    check("wr_sparsemap", wr_sparsemap_o, rec[256 +: 32]);
    check("wr_data", wr_nonzero_data_o, rec[255:0]);
`ifdef SPARSE_CHUNK_NNZ_COUNT_EN
    check("nnz_count", nnz_count_o, e_nnz);
`endif
  end

  // Driver tasks; all called in the posedge+#1 phase
  task automatic send(input logic [255:0] d);
    int waited = 0;
    dense_valid_i = 1'b1;
    dense_data_i  = d;
    while (!dense_ready_o && waited < 50) begin
      @(posedge clk_i); #1;
      waited++;
    end
    if (!dense_ready_o) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: got ready 0 expected ready 1 within 50 cycles");
    end
    @(posedge clk_i); #1;
    dense_valid_i = 1'b0;
  endtask

  task automatic release_pulse();
    rd_release_i = 1'b1;
    @(posedge clk_i); #1;
    rd_release_i = 1'b0;
  endtask

  task automatic do_reset();
    dense_valid_i = 1'b0;
    rd_release_i  = 1'b0;
    rst_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b1;
  endtask

  function automatic logic [255:0] pat(input int seed);
    logic [255:0] d;
    for (int k = 0; k < 32; k++) d[k*8 +: 8] = 8'((seed * 7 + k * 13) % 5 == 0 ? 0 : seed * 31 + k);
    return d;
  endfunction

  initial begin
    logic [255:0] d;

    // Reset state
    @(posedge clk_i); #1;
    check("rst_wr_valid", wr_valid_o, 1'b0);
    check("rst_rd_avail", rd_avail_o, 1'b0);
    check("rst_ready", dense_ready_o, 1'b1);
    rst_i = 1'b1;

    // Four all-nonzero beats fill buffer 0
    for (int k = 0; k < 32; k++) d[k*8 +: 8] = 8'(k + 1);
    for (int b = 0; b < 4; b++) begin
      send(d);
      check("a_count", wr_count_o, b);
      check("a_sel", wr_sel_o, 1'b0);
      check("a_map", wr_sparsemap_o, 32'hffff_ffff);
      check("a_done", chunk_done_o, b == 3);
    end
    check("a_rd_avail", rd_avail_o, 1'b1);
    check("a_rd_sel", rd_sel_o, 1'b0);

    // Sparse beat and all-zero beat
    do_reset();
    d = '0;
    d[3*8 +: 8]  = 8'h11;
    d[17*8 +: 8] = 8'h22;
    send(d);
    check("b_map", wr_sparsemap_o, 32'h0002_0008);
    check("b_data", wr_nonzero_data_o, 256'h2211);
    send('0);
    check("b_zero_valid", wr_valid_o, 1'b1);
    check("b_zero_map", wr_sparsemap_o, 32'h0);
    check("b_zero_data", wr_nonzero_data_o, 256'h0);
    check("b_zero_count", wr_count_o, 1);

    // Both buffers full, stall, then release
    do_reset();
    for (int b = 0; b < 8; b++) send(pat(b));
    check("c_ready_full", dense_ready_o, 1'b0);
    dense_valid_i = 1'b1;
    dense_data_i  = pat(8);
    repeat (3) begin @(posedge clk_i); #1; end
    check("c_ready_stall", dense_ready_o, 1'b0);
    check("c_valid_stall", wr_valid_o, 1'b0);
    release_pulse();
    check("c_rd_sel", rd_sel_o, 1'b1);
    check("c_ready_free", dense_ready_o, 1'b1);
    @(posedge clk_i); #1;
    dense_valid_i = 1'b0;
    check("c_9_valid", wr_valid_o, 1'b1);
    check("c_9_sel", wr_sel_o, 1'b0);
    check("c_9_count", wr_count_o, 0);

    // Last beat of buffer 1 together with release of buffer 0
    do_reset();
    for (int b = 0; b < 7; b++) send(pat(b + 20));
    rd_release_i = 1'b1;
    send(pat(27));
    rd_release_i = 1'b0;
    check("d_done", chunk_done_o, 1'b1);
    check("d_wr_sel", wr_sel_o, 1'b1);
    check("d_rd_sel", rd_sel_o, 1'b1);
    check("d_rd_avail", rd_avail_o, 1'b1);
    check("d_ready", dense_ready_o, 1'b1);
    send(pat(28));
    check("d_next_sel", wr_sel_o, 1'b0);
    check("d_next_count", wr_count_o, 0);

    // Reset in the middle of a chunk
    do_reset();
    send(pat(40));
    send(pat(41));
    rst_i = 1'b0;
    #1;
    check("e_valid", wr_valid_o, 1'b0);
    check("e_count", wr_count_o, 0);
    check("e_map", wr_sparsemap_o, 32'h0);
    check("e_data", wr_nonzero_data_o, 256'h0);
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    send(pat(42));
    check("e_after_count", wr_count_o, 0);
    check("e_after_sel", wr_sel_o, 1'b0);

    // Chunk with 5+0+32+1 nonzero bytes, then an all-zero chunk
    do_reset();
    d = '0;
    for (int k = 0; k < 5; k++) d[k*8 +: 8] = 8'(k + 1);
    send(d);
    send('0);
    for (int k = 0; k < 32; k++) d[k*8 +: 8] = 8'(k + 100);
    send(d);
    d = '0;
    d[31*8 +: 8] = 8'hff;
    send(d);
    check("f_last_data", wr_nonzero_data_o, 256'hff);
    check("f_done", chunk_done_o, 1'b1);
`ifdef SPARSE_CHUNK_NNZ_COUNT_EN
    check("f_nnz38", nnz_count_o, 38);
`endif
    for (int b = 0; b < 4; b++) send('0);
`ifdef SPARSE_CHUNK_NNZ_COUNT_EN
    check("f_nnz0", nnz_count_o, 0);
`endif
    check("f_both_full", dense_ready_o, 1'b0);

    repeat (2) @(posedge clk_i);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sparse_chunk_writer.md
Name: sparse_chunk_writer

Overview:
- Producer side of the compressed-chunk write interface (sparsemap, nonzero data, wr_valid, wr_count, wr_sel) consumed by the IFM and filter chunk buffers of the input selector.
- Accepts dense 8-bit activations or weights, one BUS_SIZE-byte beat per cycle.
- For each beat, builds the sparsemap and lane-compacted nonzero data and issues the buffer write.
- Owns the ping-pong (double-buffer) bookkeeping: which buffer is written, which buffer is readable, and when each is freed.

Parameters:
- BUS_SIZE, 32, bytes per input beat and per write cycle.
- CHUNK_SIZE, 128, bytes per chunk; must be a multiple of BUS_SIZE.
- WR_DAT_CYC_NUM, CHUNK_SIZE/BUS_SIZE, write beats per chunk (local, derived).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-low.
- dense_valid_i  in  1  input beat valid.
- dense_data_i  in  BUS_SIZE x 8  dense bytes; lane 0 is the lowest address.
- dense_ready_o  out  1  beat accepted when valid and ready are both high.
- wr_sparsemap_o  out  BUS_SIZE  bit k = (dense byte k != 0).
- wr_nonzero_data_o  out  BUS_SIZE x 8  nonzero bytes packed to lanes 0..n-1, in ascending order; upper lanes are 0.
- wr_valid_o  out  1  write strobe to the chunk buffer.
- wr_count_o  out  clog2(WR_DAT_CYC_NUM)  beat index within the chunk.
- wr_sel_o  out  1  target buffer of the current write.
- rd_sel_o  out  1  buffer the consumer must read.
- rd_avail_o  out  1  rd_sel_o buffer holds a complete chunk.
- rd_release_i  in  1  one-cycle pulse: consumer has finished the rd_sel_o buffer.
- chunk_done_o  out  1  one-cycle pulse when a chunk's last beat is written.

Behaviour:
- Reset (rst_i low, async):
  - wr_valid_o=0, wr_count_o=0, wr_sel_o=0, rd_sel_o=0.
  - full[1:0]=0, rd_avail_o=0, chunk_done_o=0.
  - Sparsemap and data outputs are 0.
  - Internal beat counter is 0.
- dense_ready_o = !full[fill_sel] (combinational). fill_sel is the internal buffer being filled.
- Accept → write latency is 1 cycle. On the cycle after an accepted beat:
  - wr_valid_o=1.
  - wr_sparsemap_o and wr_nonzero_data_o are registered from that beat.
  - wr_count_o = counter value at acceptance; wr_sel_o = fill_sel at acceptance.
  - Otherwise wr_valid_o=0 and the data outputs hold their last values.
- Compaction: output lane j = j-th nonzero input byte by ascending lane. Result is combinational from dense_data_i and registered on accept. An all-zero beat gives sparsemap 0, data 0, and is still written (wr_valid_o=1).
- Counter:
  - Increments on each accept.
  - On the accept with counter == WR_DAT_CYC_NUM-1: wraps to 0, sets full[fill_sel], toggles fill_sel, and chunk_done_o pulses together with the final wr_valid_o.
- Fill state per buffer is EMPTY or FULL:
  - EMPTY→FULL on completion of the last beat.
  - FULL→EMPTY on rd_release_i while rd_sel_o points to that buffer; rd_sel_o then toggles.
- rd_avail_o = full[rd_sel_o]. rd_release_i while rd_avail_o=0 is ignored: no toggle, no state change.
- Simultaneous last-beat completion on buffer A and release of buffer B, same cycle: both take effect. full[A] becomes 1, full[B] becomes 0. fill_sel moves to B and dense_ready_o is 1 on the next cycle.
- Both buffers full: dense_ready_o=0, the counter holds, and input stalls indefinitely until a release.
- A mid-chunk stall (valid low) keeps the counter and fill_sel; no partial-chunk flush exists.
- Reset mid-chunk discards the partial chunk and both full flags.

Optional Feature:
- Macro: SPARSE_CHUNK_NNZ_COUNT_EN.
- Defined:
  - Adds port nnz_count_o, out, clog2(CHUNK_SIZE)+1 bits.
  - Holds the total nonzero byte count of the most recently completed chunk. It updates in the same cycle chunk_done_o pulses; reset value is 0.
  - The internal accumulator sums popcount(sparsemap) per accepted beat and clears at chunk start.
- Undefined: the port and the accumulator are absent; all other behaviour is identical.

Test Plan:
- Reset, then 4 beats with byte k = k+1 (all nonzero) → wr_valid_o for 4 cycles, wr_count_o 0,1,2,3, wr_sel_o=0, sparsemap all ones, chunk_done_o on the 4th write, rd_avail_o=1, rd_sel_o=0.
- Beat with only lanes 3 and 17 nonzero (0x11, 0x22) → sparsemap = (1<<3)|(1<<17), data lane0=0x11, lane1=0x22, lanes 2..31 = 0; an all-zero beat → sparsemap 0, wr_valid_o=1.
- 8 beats with no release → both buffers full, dense_ready_o=0 from the 9th cycle on. Pulse rd_release_i → rd_sel_o=1, dense_ready_o=1 next cycle, the 9th beat writes with wr_sel_o=0, wr_count_o=0.
- Last beat of buffer 1 accepted in the same cycle as rd_release_i for buffer 0 → full becomes 2'b10, rd_sel_o=1, rd_avail_o=1, and the next write goes to buffer 0.
- Assert rst_i low after 2 beats of a chunk → all outputs 0 immediately. After release of reset, the next beat writes wr_count_o=0, wr_sel_o=0.
- SPARSE_CHUNK_NNZ_COUNT_EN defined, chunk containing 5+0+32+1 nonzero bytes → nnz_count_o=38 on the chunk_done_o cycle; an all-zero chunk → 0.
